// File: rtl/seq_div6_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_div6_pkg
// Description : Shared definitions for the sequential 6-bit restoring divider.
//               Holds the FSM state encoding, the default datapath width and
//               the iteration-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_div6_pkg;

    // Default operand / quotient / remainder width.
    localparam int c_DEFAULT_WIDTH = 6;

    // Divider control states. The encoding is fixed at 2 bits.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The iteration counter must hold 0..w, hence clog2(w+1) bits.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int c_DEFAULT_CNT_W = $clog2(c_DEFAULT_WIDTH + 1);

endpackage : seq_div6_pkg
`default_nettype wire

// File: rtl/seq_div6_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_div6_if
// Description : Start/busy/done handshake and operand/result bus of the
//               sequential divider.
//               master : drives start, dividend, divisor; observes results.
//               slave  : the divider; observes request, drives busy, done,
//                        quotient, remainder, div_by_zero.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_div6_if
    import seq_div6_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface : seq_div6_if
`default_nettype wire

// File: rtl/seq_div6_div_trial_sub.sv
`default_nettype none
// ============================================================================
// Module      : div_trial_sub
// Description : Combinational WIDTH+1-bit trial subtractor for one restoring
//               division step: diff = minuend - {0,divisor}, computed as
//               minuend + ~{0,divisor} + 1 (two's-complement invert-plus-one).
//   minuend  in  WIDTH+1  shifted partial remainder
//   divisor  in  WIDTH    unsigned divisor
//   diff     out WIDTH+1  difference (two's complement)
//   non_neg  out 1        1 when the difference is non-negative
// Revision    : 1.0 - initial release
// ============================================================================
module div_trial_sub
    import seq_div6_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   minuend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   diff,
    output logic             non_neg
);

    logic [WIDTH:0] w_sub_inv;

    assign w_sub_inv = ~{1'b0, divisor};
    // minuend < 2*divisor is guaranteed by the caller, so the result always
    // fits in WIDTH+1 signed bits and the MSB is a valid sign.
    assign diff      = minuend + w_sub_inv + {{WIDTH{1'b0}}, 1'b1};
    assign non_neg   = ~diff[WIDTH];

endmodule : div_trial_sub
`default_nettype wire

// File: rtl/seq_div6.sv
`default_nettype none
// ============================================================================
// Module      : seq_div6
// Description : Sequential unsigned restoring divider, one quotient bit per
//               clock, MSB first. Results are held until the next accepted
//               start. Divide-by-zero returns quotient = all ones,
//               remainder = dividend and flags div_by_zero.
//   clk    in  1  rising-edge clock
//   rst_n  in  1  synchronous active-low reset
//   bus    slave modport of seq_div6_if (start/dividend/divisor in;
//          busy/done/quotient/remainder/div_by_zero out)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_div6
    import seq_div6_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_div6_if.slave bus
);

    localparam int                 c_CNT_W     = cnt_width(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST_STEP = c_CNT_W'(WIDTH - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_count;
    logic [WIDTH:0]       r_partial;
    // Holds the dividend at capture; quotient bits shift in from the LSB as
    // dividend bits shift out of the MSB, so it ends up holding the quotient.
    logic [WIDTH-1:0]     r_work;
    logic [WIDTH-1:0]     r_divisor;
    logic [WIDTH-1:0]     r_quotient;
    logic [WIDTH-1:0]     r_remainder;
    logic                 r_div_by_zero;

    logic                 w_accept;
    logic                 w_last_step;
    logic [WIDTH:0]       w_shifted;
    logic [WIDTH:0]       w_diff;
    logic                 w_non_neg;
    logic [WIDTH:0]       w_partial_nxt;
    logic [WIDTH-1:0]     w_work_nxt;
    logic                 w_busy;
    logic                 w_done;

    // start is only honoured outside RUN; inside RUN it is simply dropped.
    assign w_accept    = bus.start && (r_state != RUN);
    assign w_last_step = (r_count == c_LAST_STEP);

    // --------------------------------------------------------------------
    // One restoring step
    // --------------------------------------------------------------------
    assign w_shifted = (r_partial << 1) | {{WIDTH{1'b0}}, r_work[WIDTH-1]};

    div_trial_sub #(
        .WIDTH (WIDTH)
    ) u_trial_sub (
        .minuend (w_shifted),
        .divisor (r_divisor),
        .diff    (w_diff),
        .non_neg (w_non_neg)
    );

    assign w_partial_nxt = w_non_neg ? w_diff : w_shifted;
    assign w_work_nxt    = {r_work[WIDTH-2:0], w_non_neg};

    // --------------------------------------------------------------------
    // FSM: state register
    // --------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // --------------------------------------------------------------------
    // FSM: next-state logic
    // --------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.divisor == '0) ? DONE : RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (w_last_step) begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // --------------------------------------------------------------------
    // FSM: outputs (decoded from the state register only)
    // --------------------------------------------------------------------
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            RUN:     w_busy = 1'b1;
            DONE:    w_done = 1'b1;
            default: ;
        endcase
    end

    // --------------------------------------------------------------------
    // Datapath: operands, counter, partial remainder, results
    // --------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count       <= '0;
            r_partial     <= '0;
            r_work        <= '0;
            r_divisor     <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_work    <= bus.dividend;
            r_divisor <= bus.divisor;
            r_count   <= '0;
            r_partial <= '0;
            if (bus.divisor == '0) begin
                r_quotient    <= '1;
                r_remainder   <= bus.dividend;
                r_div_by_zero <= 1'b1;
            end else begin
                r_quotient    <= '0;
                r_remainder   <= '0;
                r_div_by_zero <= 1'b0;
            end
        end else if (r_state == RUN) begin
            r_partial <= w_partial_nxt;
            r_work    <= w_work_nxt;
            r_count   <= r_count + c_CNT_W'(1);
            if (w_last_step) begin
                r_quotient  <= w_work_nxt;
                r_remainder <= w_partial_nxt[WIDTH-1:0];
            end
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;

endmodule : seq_div6
`default_nettype wire

// File: tb/tb_seq_div6.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_div6
// Description : Self-checking bench for seq_div6. A queue-based arithmetic
//               model (integer / and %) predicts every result and its
//               completion cycle; a per-cycle compare process checks busy,
//               done, results and held values; directed cases pin the model
//               with hand-computed literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_div6;

    localparam int W      = 6;
    localparam int c_ONES = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    seq_div6_if #(.WIDTH(W)) dif ();

    seq_div6 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    typedef struct {
        int q;
        int r;
        int dbz;
        int due;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   total    = 0;
    int   bad      = 0;
    int   hold_q   = 0;
    int   hold_r   = 0;
    int   hold_dbz = 0;
    bit   chk_en   = 1'b0;
    int   last_k   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected result of an operation accepted at edge k.
    function automatic void push_op(input int dvd, input int dvs, input int k);
        exp_t e;
        if (dvs == 0) begin
            e.q = c_ONES; e.r = dvd; e.dbz = 1; e.due = k;
        end else begin
            e.q = dvd / dvs; e.r = dvd % dvs; e.dbz = 0; e.due = k + W;
        end
        sb.push_back(e);
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin : p_cmp
        exp_t e;
        bit   exp_busy;
        if (chk_en) begin
            exp_busy = (sb.size() > 0) && (sb[0].dbz == 0) && (cyc < sb[0].due);
            chk("busy", int'(dif.busy), int'(exp_busy));
            chk("busy_and_done", int'(dif.busy & dif.done), 0);
            if (dif.done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("mdl_quotient", int'(dif.quotient), e.q);
                    chk("mdl_remainder", int'(dif.remainder), e.r);
                    chk("mdl_div_by_zero", int'(dif.div_by_zero), e.dbz);
                    chk("mdl_done_cycle", cyc, e.due);
                    hold_q = e.q; hold_r = e.r; hold_dbz = e.dbz;
                end
            end else begin
                if (sb.size() > 0 && sb[0].due < cyc) begin
                    chk("missing_done", cyc, sb[0].due);
                    void'(sb.pop_front());
                end
                if (exp_busy) begin
                    chk("run_quotient_clear", int'(dif.quotient), 0);
                    chk("run_remainder_clear", int'(dif.remainder), 0);
                    chk("run_dbz_clear", int'(dif.div_by_zero), 0);
                end else begin
                    chk("held_quotient", int'(dif.quotient), hold_q);
                    chk("held_remainder", int'(dif.remainder), hold_r);
                    chk("held_dbz", int'(dif.div_by_zero), hold_dbz);
                end
            end
        end
    end

    task automatic issue(input int dvd, input int dvs, input bit keep);
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = W'(dvd);
        dif.divisor  = W'(dvs);
        @(posedge clk);
        #1;
        last_k = cyc;
        push_op(dvd, dvs, cyc);
        if (!keep) dif.start = 1'b0;
    endtask

    // Returns at the falling edge of the done cycle (bounded).
    task automatic wait_done(output int busy_cnt);
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dif.done) return;
            if (dif.busy) busy_cnt++;
        end
        chk("done_timeout", int'(dif.done), 1);
    endtask

    task automatic check_result(input string name, input int eq, input int er,
                                input int edbz, input int elat);
        chk({name, "_quotient"}, int'(dif.quotient), eq);
        chk({name, "_remainder"}, int'(dif.remainder), er);
        chk({name, "_div_by_zero"}, int'(dif.div_by_zero), edbz);
        chk({name, "_latency"}, cyc - last_k, elat);
    endtask

    task automatic run_op(input string name, input int dvd, input int dvs,
                          input int eq, input int er, input int edbz,
                          input int elat, input int ebusy);
        int bc;
        issue(dvd, dvs, 1'b0);
        wait_done(bc);
        check_result(name, eq, er, edbz, elat);
        chk({name, "_busy_cycles"}, bc, ebusy);
    endtask

    task automatic check_zero_outputs(input string name);
        chk({name, "_busy"}, int'(dif.busy), 0);
        chk({name, "_done"}, int'(dif.done), 0);
        chk({name, "_quotient"}, int'(dif.quotient), 0);
        chk({name, "_remainder"}, int'(dif.remainder), 0);
        chk({name, "_div_by_zero"}, int'(dif.div_by_zero), 0);
    endtask

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : p_main
        int bc;
        int d1;

        rst_n        = 1'b0;
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Main case and edge values.
        run_op("d45_6",  45,  6,  7,  3, 0, 6, 6);
        run_op("d63_1",  63,  1, 63,  0, 0, 6, 6);
        run_op("d5_9",    5,  9,  0,  5, 0, 6, 6);
        run_op("d0_7",    0,  7,  0,  0, 0, 6, 6);
        run_op("d63_63", 63, 63,  1,  0, 0, 6, 6);

        // Divide by zero completes in the cycle right after the accept.
        run_op("d20_0",  20,  0, 63, 20, 1, 0, 0);
        run_op("d20_4",  20,  4,  5,  0, 0, 6, 6);

        // Start pulsed during RUN must be ignored.
        issue(40, 3, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        dif.start    = 1'b1;
        dif.dividend = W'(10);
        dif.divisor  = W'(2);
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        wait_done(bc);
        check_result("d40_3_ign", 13, 1, 0, 6);

        // Back-to-back: start held high, new operands during the done cycle.
        issue(50, 7, 1'b1);
        wait_done(bc);
        d1 = cyc;
        check_result("b2b_first", 7, 1, 0, 6);
        dif.dividend = W'(33);
        dif.divisor  = W'(4);
        @(posedge clk);
        #1;
        last_k = cyc;
        push_op(33, 4, cyc);
        dif.start = 1'b0;
        wait_done(bc);
        check_result("b2b_second", 8, 1, 0, 6);
        // One operation per WIDTH+1 cycles at full throughput.
        chk("b2b_done_gap", cyc - d1, W + 1);

        // Reset after step 3 of a 45/6 run.
        issue(45, 6, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        hold_q = 0; hold_r = 0; hold_dbz = 0;
        check_zero_outputs("mid_reset");
        rst_n = 1'b1;
        run_op("d45_6_again", 45, 6, 7, 3, 0, 6, 6);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_seq_div6
`default_nettype wire
